// File: rtl/load_align_ext.sv
// rtl/load_align_ext.sv - load-return lane alignment, two-beat merge and sign/zero extension
module load_align_ext #(
    parameter int XLEN     = 64,
    parameter bit SPLIT_EN = 1'b1,
    localparam int NB      = XLEN / 8,
    localparam int OFFW    = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    input  logic [OFFW-1:0] in_offset,
    input  logic [1:0]      in_size,
    input  logic            in_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_err
);

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_HI = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [OFFW-1:0] off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            sgn_q, sgn_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic            out_err_q, out_err_d;

    logic              free;
    logic              accept;
    logic              span;
    logic              illegal;
    int                nbytes;
    int                nbits;
    logic [2*XLEN-1:0] cat;
    logic [2*XLEN-1:0] shifted;
    logic [OFFW-1:0]   sel_off;
    logic [1:0]        sel_size;
    logic              sel_sgn;
    logic              ext_bit;
    logic [XLEN-1:0]   result;

    assign free      = !out_valid_q || out_ready;
    assign accept    = in_valid && free;
    assign in_ready  = free;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

    // Boundary test always uses the live beat: it only matters for a first beat.
    always_comb begin
        nbytes  = 32'd1 << in_size;
        span    = (int'(in_offset) + nbytes) > NB;
        illegal = ((XLEN == 32) && (in_size == 2'd3)) || (span && !SPLIT_EN);
    end

    // In WAIT_HI the latched fields and LO win; otherwise the beat stands alone.
    always_comb begin
        if (state_q == WAIT_HI) begin
            cat      = {in_data, lo_q};
            sel_off  = off_q;
            sel_size = size_q;
            sel_sgn  = sgn_q;
        end else begin
            cat      = {{XLEN{1'b0}}, in_data};
            sel_off  = in_offset;
            sel_size = in_size;
            sel_sgn  = in_signed;
        end
        shifted = cat >> {sel_off, 3'b000};
        nbits   = 32'd8 << sel_size;
        case (sel_size)
            2'd0:    ext_bit = sel_sgn && shifted[7];
            2'd1:    ext_bit = sel_sgn && shifted[15];
            2'd2:    ext_bit = sel_sgn && shifted[31];
            default: ext_bit = sel_sgn && shifted[XLEN-1];
        endcase
        result = '0;
        for (int i = 0; i < XLEN; i++) begin
            result[i] = (i < nbits) ? shifted[i] : ext_bit;
        end
    end

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        off_d       = off_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (illegal) begin
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b1;
                        out_data_d  = '0;
                    end else if (!span) begin
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b0;
                        out_data_d  = result;
                    end else begin
                        state_d = WAIT_HI;
                        lo_d    = in_data;
                        off_d   = in_offset;
                        size_d  = in_size;
                        sgn_d   = in_signed;
                    end
                end
                default: begin
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b0;
                    out_data_d  = result;
                    state_d     = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lo_q        <= '0;
            off_q       <= '0;
            size_q      <= '0;
            sgn_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            off_q       <= off_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

endmodule
